// File: rtl/sync_edge_detect_mc.sv
// Multi-channel synchroniser + glitch filter + edge/event detector with saturating per-channel counters.
// din->dout latency SYNC_STAGES+FILT_CYC cycles; no backpressure, every cycle is accepted.
module sync_edge_detect_mc #(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYC    = 1,
  parameter int CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CH-1:0]         din,
  input  logic [2*CH-1:0]       mode,
  input  logic                  clr_cnt,
  output logic [CH-1:0]         dout,
  output logic [CH-1:0]         rise,
  output logic [CH-1:0]         fall,
  output logic [CH-1:0]         evt,
  output logic [CH*CNT_W-1:0]   evt_cnt
);

  localparam int FW = (FILT_CYC < 1) ? 1 : $clog2(FILT_CYC + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILT_CYC - 1);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_lvl;
    logic                   r_lvl_p;
    logic [FW-1:0]          r_filt;
    logic [CNT_W-1:0]       r_cnt;
    logic                   w_s_last;
    logic                   w_rise;
    logic                   w_fall;
    logic                   w_evt;

    assign w_s_last = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
      if (rst) begin
        r_sync  <= '0;
        r_lvl   <= 1'b0;
        r_lvl_p <= 1'b0;
        r_filt  <= '0;
      end else begin
        r_sync  <= {r_sync[SYNC_STAGES-2:0], din[i]};
        r_lvl_p <= r_lvl;
        // Any cycle agreeing with the accepted level restarts the stability count.
        if (w_s_last == r_lvl) begin
          r_filt <= '0;
        end else if (r_filt == FILT_LAST) begin
          r_lvl  <= ~r_lvl;
          r_filt <= '0;
        end else begin
          r_filt <= r_filt + 1'b1;
        end
      end
    end

    assign w_rise = r_lvl & ~r_lvl_p;
    assign w_fall = ~r_lvl & r_lvl_p;
    assign w_evt  = (mode[2*i] & w_rise) | (mode[2*i+1] & w_fall);

    // Clear wins over a coincident event; the count sticks at all-ones.
    always_ff @(posedge clk) begin
      if (rst || clr_cnt) begin
        r_cnt <= '0;
      end else if (w_evt && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    assign dout[i]                 = r_lvl;
    assign rise[i]                 = w_rise;
    assign fall[i]                 = w_fall;
    assign evt[i]                  = w_evt;
    assign evt_cnt[i*CNT_W +: CNT_W] = r_cnt;
  end

endmodule

// File: tb/tb_sync_edge_detect_mc.sv
// Randomised and directed bench for sync_edge_detect_mc against a window-based reference model.
module tb_sync_edge_detect_mc;
  localparam int CH = 4;
  localparam int SS = 2;
  localparam int FC = 3;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [CH-1:0]     din;
  logic [2*CH-1:0]   mode;
  logic              clr_cnt;
  logic [CH-1:0]     dout;
  logic [CH-1:0]     rise;
  logic [CH-1:0]     fall;
  logic [CH-1:0]     evt;
  logic [CH*CW-1:0]  evt_cnt;

  always #5 clk = ~clk;

  sync_edge_detect_mc #(.CH(CH), .SYNC_STAGES(SS), .FILT_CYC(FC), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .din(din), .mode(mode), .clr_cnt(clr_cnt),
    .dout(dout), .rise(rise), .fall(fall), .evt(evt), .evt_cnt(evt_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: din delayed SS samples, then a level flips once the last FC
  // delayed samples all disagree with it.
  bit m_dly [CH][SS];
  bit m_win [CH][FC];
  bit m_lvl [CH];
  bit m_lvlp[CH];
  int m_cnt [CH];
  int obs_rise[CH];
  int obs_fall[CH];
  int obs_evt [CH];

  function automatic bit m_evt(int c);
    return (mode[2*c] & m_lvl[c] & ~m_lvlp[c]) | (mode[2*c+1] & ~m_lvl[c] & m_lvlp[c]);
  endfunction

  task automatic model_edge();
    for (int c = 0; c < CH; c++) begin
      if (rst) begin
        for (int k = 0; k < SS; k++) m_dly[c][k] = 1'b0;
        for (int k = 0; k < FC; k++) m_win[c][k] = 1'b0;
        m_lvl[c] = 1'b0; m_lvlp[c] = 1'b0; m_cnt[c] = 0;
      end else begin
        bit s;
        bit all_diff;
        if (clr_cnt) m_cnt[c] = 0;
        else if (m_evt(c) && m_cnt[c] < CMAX) m_cnt[c]++;
        s = m_dly[c][SS-1];
        for (int k = FC-1; k > 0; k--) m_win[c][k] = m_win[c][k-1];
        m_win[c][0] = s;
        m_lvlp[c] = m_lvl[c];
        all_diff = 1'b1;
        for (int k = 0; k < FC; k++) if (m_win[c][k] == m_lvl[c]) all_diff = 1'b0;
        if (all_diff) begin
          m_lvl[c] = ~m_lvl[c];
          for (int k = 0; k < FC; k++) m_win[c][k] = m_lvl[c];
        end
        for (int k = SS-1; k > 0; k--) m_dly[c][k] = m_dly[c][k-1];
        m_dly[c][0] = din[c];
      end
    end
  endtask

  task automatic check_all();
    for (int c = 0; c < CH; c++) begin
      check($sformatf("dout%0d", c), 32'(dout[c]), 32'(m_lvl[c]));
      check($sformatf("rise%0d", c), 32'(rise[c]), 32'(m_lvl[c] & ~m_lvlp[c]));
      check($sformatf("fall%0d", c), 32'(fall[c]), 32'(~m_lvl[c] & m_lvlp[c]));
      check($sformatf("evt%0d", c),  32'(evt[c]),  32'(m_evt(c)));
      check($sformatf("cnt%0d", c),  32'(evt_cnt[c*CW +: CW]), 32'(m_cnt[c]));
      obs_rise[c] += int'(rise[c]);
      obs_fall[c] += int'(fall[c]);
      obs_evt[c]  += int'(evt[c]);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic clear_obs();
    for (int c = 0; c < CH; c++) begin
      obs_rise[c] = 0; obs_fall[c] = 0; obs_evt[c] = 0;
    end
  endtask

  task automatic pulse_clr();
    clr_cnt = 1'b1;
    cycle();
    clr_cnt = 1'b0;
  endtask

  initial begin
    bit found;
    int snap;
    rst = 1'b1; din = 4'hF; mode = 8'hFF; clr_cnt = 1'b0;

    // Reset with din high, then release: dout/rise appear at the 5th edge.
    cycles(3);
    check("rst_dout", 32'(dout), 32'h0);
    check("rst_cnt", 32'(evt_cnt), 32'h0);
    rst = 1'b0;
    cycles(4);
    check("rel_dout_e4", 32'(dout), 32'h0);
    cycle();
    check("rel_dout_e5", 32'(dout), 32'hF);
    check("rel_rise_e5", 32'(rise), 32'hF);
    cycle();
    check("rel_rise_e6", 32'(rise), 32'h0);

    // Glitch filter on ch0.
    din = 4'h0;
    cycles(10);
    pulse_clr();
    clear_obs();
    din[0] = 1'b1; cycles(2); din[0] = 1'b0; cycles(10);
    check("glitch2_rise", 32'(obs_rise[0]), 32'd0);
    check("glitch2_dout", 32'(dout[0]), 32'd0);
    check("glitch2_cnt", 32'(evt_cnt[0 +: CW]), 32'd0);
    din[0] = 1'b1; cycles(3); din[0] = 1'b0; cycles(10);
    check("glitch3_rise", 32'(obs_rise[0]), 32'd1);

    // Fall-only mode on ch1.
    mode = 8'b11_11_10_11;
    pulse_clr();
    clear_obs();
    din[1] = 1'b1; cycles(5); din[1] = 1'b0; cycles(15);
    check("fonly_rise", 32'(obs_rise[1]), 32'd1);
    check("fonly_fall", 32'(obs_fall[1]), 32'd1);
    check("fonly_evt", 32'(obs_evt[1]), 32'd1);
    check("fonly_cnt", 32'(evt_cnt[CW +: CW]), 32'd1);

    // Saturation on ch2 with both edges counted.
    mode = 8'hFF;
    pulse_clr();
    for (int t = 0; t < 20; t++) begin
      din[2] = 1'b1; cycles(5);
      din[2] = 1'b0; cycles(5);
    end
    cycles(6);
    check("sat_cnt", 32'(evt_cnt[2*CW +: CW]), 32'(CMAX));
    din[2] = 1'b1; cycles(8); din[2] = 1'b0; cycles(8);
    check("sat_hold", 32'(evt_cnt[2*CW +: CW]), 32'(CMAX));

    // Clear racing an event on ch3 at count 7.
    pulse_clr();
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      if (i % 6 == 0) din[3] = ~din[3];
      cycle();
      if (evt[3] && evt_cnt[3*CW +: CW] == 4'd7) begin
        clr_cnt = 1'b1;
        cycle();
        clr_cnt = 1'b0;
        check("race_cnt", 32'(evt_cnt[3*CW +: CW]), 32'd0);
        found = 1'b1;
      end
    end
    check("race_reached", 32'(found), 32'd1);

    // Fully random traffic including mid-filter resets and clears.
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < CH; c++) if ($urandom_range(3) == 0) din[c] = ~din[c];
      mode    = 8'($urandom);
      clr_cnt = ($urandom_range(19) == 0);
      rst     = ($urandom_range(49) == 0);
      cycle();
    end
    rst = 1'b0; clr_cnt = 1'b0;

    // Independence: ch3 static, others random.
    din[3] = 1'b1; mode[7:6] = 2'b11;
    cycles(12);
    clear_obs();
    snap = m_cnt[3];
    for (int i = 0; i < 300; i++) begin
      for (int c = 0; c < 3; c++) if ($urandom_range(2) == 0) din[c] = ~din[c];
      mode[5:0] = 6'($urandom);
      cycle();
    end
    check("ind_dout3", 32'(dout[3]), 32'd1);
    check("ind_rise3", 32'(obs_rise[3]), 32'd0);
    check("ind_fall3", 32'(obs_fall[3]), 32'd0);
    check("ind_evt3", 32'(obs_evt[3]), 32'd0);
    check("ind_cnt3", 32'(evt_cnt[3*CW +: CW]), 32'(snap));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sync_edge_detect_mc.md
SYNC_EDGE_DETECT_MC -- requirements
Module: sync_edge_detect_mc

Interface
REQ-001 SHALL provide parameter CH, default 4: number of independent channels (1..32).
REQ-002 SHALL provide parameter SYNC_STAGES, default 2: synchroniser flop depth (>=2).
REQ-003 SHALL provide parameter FILT_CYC, default 1: consecutive cycles a new level must be stable before acceptance (>=1; 1 = no filtering).
REQ-004 SHALL provide parameter CNT_W, default 8: width of each per-channel event counter (1..16).
REQ-005 SHALL have port clk  input  1  sole clock; all logic on posedge clk.
REQ-006 SHALL have port rst  input  1  synchronous reset, active-high.
REQ-007 SHALL have port din  input  CH  asynchronous level inputs from a foreign clock domain.
REQ-008 SHALL have port mode  input  2*CH  per-channel event select, bits [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both.
REQ-009 SHALL have port clr_cnt  input  1  synchronous clear of all event counters.
REQ-010 SHALL have port dout  output  CH  synchronised, filtered level.
REQ-011 SHALL have port rise  output  CH  one-cycle rising-edge pulse of dout.
REQ-012 SHALL have port fall  output  CH  one-cycle falling-edge pulse of dout.
REQ-013 SHALL have port evt  output  CH  mode-qualified edge pulse.
REQ-014 SHALL have port evt_cnt  output  CH*CNT_W  per-channel event counters, channel i at [i*CNT_W +: CNT_W].

Function
REQ-015 Each channel SHALL pass din[i] through a SYNC_STAGES flop chain; only the last stage (s_last) feeds further logic.
REQ-016 Each channel SHALL hold a level register lvl (driving dout) and a previous-level register lvl_p loaded from lvl every cycle.
REQ-017 Each channel SHALL hold a filter counter of width clog2(FILT_CYC+1), cleared in every cycle where s_last equals lvl.
REQ-018 lvl SHALL toggle on the clock edge where s_last has differed from lvl for FILT_CYC consecutive sampled cycles; the filter counter SHALL clear on that edge.
REQ-019 A difference shorter than FILT_CYC cycles SHALL leave lvl unchanged and produce no pulse.
REQ-020 Latency from a stable din change (set up before edge 1) to dout change SHALL be exactly SYNC_STAGES+FILT_CYC cycles (visible after that edge).
REQ-021 rise[i] SHALL equal lvl & ~lvl_p; fall[i] SHALL equal ~lvl & lvl_p; both SHALL be high exactly one cycle, in the first cycle dout shows the new level.
REQ-022 evt[i] SHALL equal (mode bit0 & rise[i]) | (mode bit1 & fall[i]); mode changes SHALL take effect in the same cycle, with no pulse generated by a mode change itself.
REQ-023 Mode 00 SHALL suppress evt and counting only; dout, rise and fall SHALL remain active.
REQ-024 evt_cnt[i] SHALL increment by 1 on each clock edge where evt[i]=1, with the result visible the following cycle.
REQ-025 evt_cnt[i] SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-026 clr_cnt=1 SHALL set all counters to 0 on that edge, overriding a coincident increment.
REQ-027 Channels SHALL be fully independent; activity on one channel SHALL NOT alter any other channel's outputs.
REQ-028 All outputs SHALL be driven from registers or from combinational logic of registers plus mode only; there SHALL be no combinational path from din.

Reset
REQ-029 rst=1 SHALL clear all sync stages, lvl, lvl_p, filter counters and evt_cnt to 0 on the next edge.
REQ-030 During reset and in the first cycle after reset, dout, rise, fall and evt SHALL be 0 and evt_cnt SHALL be 0.
REQ-031 Reset asserted mid-filter or mid-pulse SHALL abort it; no pulse SHALL survive reset.
REQ-032 A din held high through reset release SHALL yield one rise pulse SHALL_SYNC_STAGES+FILT_CYC cycles after release; this pulse is legal.

Verification (CH=4, SYNC_STAGES=2, FILT_CYC=3, CNT_W=4)
REQ-033 Reset: rst high 3 cycles with din=4'hF -> outputs 0; after release, dout=4'hF and rise=4'hF for one cycle at edge 5.
REQ-034 Glitch: din[0] high 2 cycles -> dout[0], rise[0] and evt_cnt stay 0; high 3 cycles -> exactly one rise[0].
REQ-035 Mode fall-only: mode[3:2]=10, ch1 pulses high 5 cycles -> evt[1] only with fall[1]; evt_cnt ch1=1.
REQ-036 Saturation: mode[5:4]=11, 20 full toggles on ch2 -> evt_cnt ch2 reaches 15 and holds 15.
REQ-037 Clear race: clr_cnt=1 in a cycle with evt[3]=1 and count 7 -> count 0 next cycle, not 1.
REQ-038 Independence: random din on ch0-2, ch3 static -> ch3 dout, rise, fall, evt and count unchanged.
